// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Sends DATA_WIDTH payload bits as one frame: a start bit, the data LSB first,
// an optional parity bit, then one or two stop bits. An internal baud divider
// sets the bit period to BAUD_DIV+1 clocks. The frame settings are captured
// when a request is accepted, so input changes during a frame are ignored.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous reset, active low
//   P_DATA      parallel payload, captured on accept
//   Data_Valid  send request, accepted only while idle
//   PAR_EN      1 = append a parity bit
//   PAR_TYP     1 = odd parity, 0 = even parity
//   STOP2       1 = two stop bits, 0 = one stop bit
//   BAUD_DIV    clocks per bit minus 1
//   TX_OUT      registered serial line, idle high
//   busy        high from the first start-bit cycle to the last stop-bit cycle
//   TX_DONE     one-cycle pulse in the idle cycle that follows a frame
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  TX_DONE
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_next;
  logic [DIV_WIDTH-1:0]  baud_cnt, baud_cnt_next;
  logic [IDX_W-1:0]      bit_idx, bit_idx_next;
  logic                  stop_cnt, stop_cnt_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_next;
  logic                  par_en_q, par_bit_q, stop2_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  tx_next, busy_next, done_next;
  logic                  armed;
  logic                  accept, bit_end;

  // armed stays low for the first edge after reset release, so a request
  // present on the very edge that RST deasserts is never taken.
  assign accept  = (state == IDLE) && Data_Valid && armed;
  assign bit_end = (baud_cnt == div_q);

  // State register, output flops and the captured frame settings.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      div_q     <= '0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      TX_DONE   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      armed    <= 1'b1;
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      stop_cnt <= stop_cnt_next;
      shift_q  <= shift_next;
      TX_OUT   <= tx_next;
      busy     <= busy_next;
      TX_DONE  <= done_next;
      if (accept) begin
        par_en_q  <= PAR_EN;
        // Even parity is the XOR of the data; odd parity is its inverse.
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
        stop2_q   <= STOP2;
        div_q     <= BAUD_DIV;
      end
    end
  end

  // Next-state logic. TX_OUT's next value is only changed at bit boundaries,
  // so the registered line never glitches within a bit period.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    stop_cnt_next = stop_cnt;
    shift_next    = shift_q;
    tx_next       = TX_OUT;
    busy_next     = busy;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next    = START;
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          stop_cnt_next = 1'b0;
          shift_next    = P_DATA;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next    = DATA;
          baud_cnt_next = '0;
          tx_next       = shift_q[0];
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            bit_idx_next = '0;
            if (par_en_q) begin
              state_next = PARITY;
              tx_next    = par_bit_q;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            // The shift register keeps the bit on air at position 0.
            bit_idx_next = bit_idx + 1'b1;
            shift_next   = shift_q >> 1;
            tx_next      = shift_q[1];
          end
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next    = STOP;
          baud_cnt_next = '0;
          tx_next       = 1'b1;
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (stop2_q && !stop_cnt) begin
            stop_cnt_next = 1'b1;
          end else begin
            state_next    = IDLE;
            stop_cnt_next = 1'b0;
            tx_next       = 1'b1;
            busy_next     = 1'b0;
            done_next     = 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param (DATA_WIDTH=8).
// The stimulus process queues each frame's hand-written bit sequence; an
// independent monitor pops an entry whenever busy rises and checks the line
// bit by bit, the frame length, the TX_DONE pulse and the idle gap.
module tb_uart_tx_param;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic [7:0] BAUD_DIV;
  logic       TX_OUT;
  logic       busy;
  logic       TX_DONE;

  typedef struct {
    string bits;
    int    cpb;
    int    gap;
    bit    abort;
  } exp_t;

  exp_t exp_q[$];
  int   total_checks = 0;
  int   fail_checks  = 0;

  uart_tx_param #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .BAUD_DIV   (BAUD_DIV),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .TX_DONE    (TX_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input bit ok, input string name, input int act, input int req);
    total_checks++;
    if (!ok) begin
      fail_checks++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic pushExpect(input string bits, input int cpb, input int gap, input bit abort);
    exp_t e;
    e.bits  = bits;
    e.cpb   = cpb;
    e.gap   = gap;
    e.abort = abort;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt,
                               input logic s2, input logic [7:0] div,
                               input string bits, input int gap, input bit abort);
    @(negedge CLK);
    P_DATA   = d;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    STOP2    = s2;
    BAUD_DIV = div;
    pushExpect(bits, int'(div) + 1, gap, abort);
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  task automatic waitBusy(input logic level, input int budget, input string name);
    int n = 0;
    while (busy !== level && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (busy !== level) checkOutput(1'b0, name, int'(busy), int'(level));
  endtask

  task automatic waitFrame();
    waitBusy(1'b1, 50, "timeout_busy_rise");
    waitBusy(1'b0, 200, "timeout_busy_fall");
    repeat (3) @(negedge CLK);
  endtask

  // Monitor: pops one expected frame per rising edge of busy.
  initial begin : monitor
    exp_t e;
    int   idle_run;
    int   n;
    int   act;
    bit   ok;
    logic eb;
    idle_run = 0;
    forever begin
      @(negedge CLK);
      if (!busy) begin
        if (TX_DONE) checkOutput(1'b0, "stray_done", 1, 0);
        idle_run++;
      end else if (exp_q.size() == 0) begin
        checkOutput(1'b0, "unexpected_frame", 1, 0);
        n = 0;
        while (busy && n < 2000) begin
          @(negedge CLK);
          n++;
        end
        idle_run = 0;
      end else begin
        e = exp_q.pop_front();
        if (e.gap >= 0) checkOutput(idle_run == e.gap, "idle_gap", idle_run, e.gap);
        if (e.abort) begin
          n = 0;
          while (busy && n < 2000) begin
            @(negedge CLK);
            n++;
          end
          ok = !busy;
          repeat (4) begin
            @(negedge CLK);
            if (TX_DONE) ok = 1'b0;
          end
          checkOutput(ok, "abort_no_done", int'(ok), 1);
          idle_run = 0;
        end else begin
          for (int b = 0; b < e.bits.len(); b++) begin
            eb  = (e.bits.getc(b) == 8'h31);
            ok  = 1'b1;
            act = int'(eb);
            for (int c = 0; c < e.cpb; c++) begin
              if (b != 0 || c != 0) @(negedge CLK);
              if (busy !== 1'b1 || TX_DONE !== 1'b0) begin
                ok  = 1'b0;
                act = -1;
              end else if (TX_OUT !== eb) begin
                ok  = 1'b0;
                act = int'(TX_OUT);
              end
            end
            checkOutput(ok, $sformatf("bit%0d_tx", b), act, int'(eb));
          end
          @(negedge CLK);
          checkOutput(busy === 1'b0 && TX_DONE === 1'b1 && TX_OUT === 1'b1, "frame_end",
                      int'({busy, TX_DONE, TX_OUT}), 3);
          idle_run = 1;
        end
      end
    end
  end

  // Stimulus
  initial begin : stimulus
    int n;
    RST        = 1'b0;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    STOP2      = 1'b0;
    BAUD_DIV   = 8'd0;
    repeat (3) @(negedge CLK);
    checkOutput(TX_OUT === 1'b1, "reset_tx", int'(TX_OUT), 1);
    checkOutput(busy === 1'b0, "reset_busy", int'(busy), 0);
    checkOutput(TX_DONE === 1'b0, "reset_done", int'(TX_DONE), 0);

    // A5, one clock per bit; request present on the reset-release edge
    P_DATA = 8'hA5;
    pushExpect("0101001011", 1, -1, 1'b0);
    @(posedge CLK);
    RST        = 1'b1;
    Data_Valid = 1'b1;
    @(negedge CLK);
    checkOutput(busy === 1'b0, "no_accept_on_release", int'(busy), 0);
    @(negedge CLK);
    Data_Valid = 1'b0;
    waitFrame();

    // 07 with parity, 4 clocks per bit: even then odd
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 8'd3, "01110000011", -1, 1'b0);
    waitFrame();
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 8'd3, "01110000001", -1, 1'b0);
    waitFrame();

    // FF, two stop bits, 2 clocks per bit
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, 8'd1, "01111111111", -1, 1'b0);
    waitFrame();

    // 3C at 3 clocks per bit; inputs scrambled and a request pulsed mid-frame
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 8'd2, "0001111001", -1, 1'b0);
    repeat (5) @(negedge CLK);
    P_DATA     = 8'hFF;
    BAUD_DIV   = 8'd0;
    PAR_EN     = 1'b1;
    STOP2      = 1'b1;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    waitBusy(1'b0, 100, "timeout_busy_fall");
    repeat (5) @(negedge CLK);

    // Request held high: back-to-back frames with one idle cycle between
    @(negedge CLK);
    P_DATA   = 8'h5A;
    BAUD_DIV = 8'd0;
    PAR_EN   = 1'b0;
    STOP2    = 1'b0;
    pushExpect("0010110101", 1, -1, 1'b0);
    pushExpect("0110000111", 1, 1, 1'b0);
    Data_Valid = 1'b1;
    waitBusy(1'b1, 50, "timeout_busy_rise");
    P_DATA = 8'hC3;
    waitBusy(1'b0, 50, "timeout_busy_fall");
    waitBusy(1'b1, 50, "timeout_busy_rise");
    Data_Valid = 1'b0;
    waitBusy(1'b0, 50, "timeout_busy_fall");
    repeat (3) @(negedge CLK);

    // Reset during data bit 3 (a 0 bit of A5), then a clean frame
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 8'd3, "", -1, 1'b1);
    waitBusy(1'b1, 50, "timeout_busy_rise");
    repeat (16) @(negedge CLK);
    checkOutput(TX_OUT === 1'b0, "bit3_before_reset", int'(TX_OUT), 0);
    #2 RST = 1'b0;
    #1;
    checkOutput(TX_OUT === 1'b1, "abort_tx", int'(TX_OUT), 1);
    checkOutput(busy === 1'b0, "abort_busy", int'(busy), 0);
    @(negedge CLK);
    #2 RST = 1'b1;
    repeat (3) @(negedge CLK);
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 8'd0, "0101001011", -1, 1'b0);
    waitFrame();

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    repeat (5) @(negedge CLK);
    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule
